// File: rtl/qsys_cpu_ocimem_arbiter_pkg.sv
// Shared types and constants for the OCI debug RAM arbiter.
package qsys_cpu_ocimem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StAck
  } state_e;

  typedef enum logic {
    OwnJtag,
    OwnAv
  } owner_e;

  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 3;
  localparam int unsigned CntW     = 2;

  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat >= RdLatMin) && (lat <= RdLatMax);
  endfunction

endpackage

// File: rtl/qsys_cpu_ocimem_arbiter_if.sv
// Avalon debug slave bus as seen by the arbiter (slave) and the CPU side (master).
interface qsys_cpu_ocimem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   av_address;
  logic                av_read;
  logic                av_write;
  logic [DATA_W-1:0]   av_writedata;
  logic [DATA_W/8-1:0] av_byteenable;
  logic                av_debugaccess;
  logic [DATA_W-1:0]   av_readdata;
  logic                av_waitrequest;

  modport master (
    output av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/qsys_cpu_ocimem_jtag_holding.sv
// Single-entry holding register for JTAG OCI RAM requests with sticky overrun detection.
module qsys_cpu_ocimem_jtag_holding #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_grant,
  input  logic              i_overrun_clr,
  output logic              o_pending,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_overrun
);

  logic              r_pending;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_overrun;
  logic              w_accept;
  logic              w_overrun_set;

  // The slot frees up on the grant edge, so a request in that same cycle still fits.
  assign w_accept      = i_req & (~r_pending | i_grant);
  assign w_overrun_set = i_req & r_pending & ~i_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= i_req | (r_pending & ~i_grant);
      if (w_accept) begin
        r_wr    <= i_wr;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (i_overrun_clr) begin
        r_overrun <= 1'b0;
      end else if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_wr      = r_wr;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/qsys_cpu_ocimem_arbiter.sv
// Round-robin arbiter sequencing JTAG and Avalon debug accesses onto the single-port OCI RAM.
module qsys_cpu_ocimem_arbiter
  import qsys_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                jtag_req,
  input  logic                jtag_wr,
  input  logic [ADDR_W-1:0]   jtag_addr,
  input  logic [DATA_W-1:0]   jtag_wdata,
  output logic [DATA_W-1:0]   jtag_rdata,
  output logic                jtag_done,
  output logic                jtag_busy,
  output logic                jtag_overrun,
  input  logic                jtag_overrun_clr,
  qsys_cpu_ocimem_arbiter_if.slave av,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wren,
  output logic [DATA_W/8-1:0] ram_byteen,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
    $error("RD_LATENCY must be in the range 1..3");
  end

  state_e              r_state;
  owner_e              r_owner;
  owner_e              r_last_grant;
  logic                r_op_wr;
  logic [CntW-1:0]     r_cnt;
  logic [DATA_W-1:0]   r_rdata_q;
  logic [DATA_W-1:0]   r_jtag_rdata;
  logic                r_jtag_done;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_wren;
  logic [DATA_W/8-1:0] r_ram_byteen;
  logic [DATA_W-1:0]   r_ram_wdata;

  logic                w_hold_pending;
  logic                w_hold_wr;
  logic [ADDR_W-1:0]   w_hold_addr;
  logic [DATA_W-1:0]   w_hold_wdata;
  logic                w_av_valid;
  logic                w_idle;
  logic                w_grant_jtag;
  logic                w_jtag_grant;

  assign w_av_valid   = av.av_read | av.av_write;
  assign w_idle       = (r_state == StIdle);
  // On a tie the requester that did not win last time goes first.
  assign w_grant_jtag = w_hold_pending & (~w_av_valid | (r_last_grant == OwnAv));
  assign w_jtag_grant = w_idle & w_grant_jtag;

  qsys_cpu_ocimem_jtag_holding #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_holding (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req         (jtag_req),
    .i_wr          (jtag_wr),
    .i_addr        (jtag_addr),
    .i_wdata       (jtag_wdata),
    .i_grant       (w_jtag_grant),
    .i_overrun_clr (jtag_overrun_clr),
    .o_pending     (w_hold_pending),
    .o_wr          (w_hold_wr),
    .o_addr        (w_hold_addr),
    .o_wdata       (w_hold_wdata),
    .o_overrun     (jtag_overrun)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_owner      <= OwnAv;
      r_last_grant <= OwnAv;
      r_op_wr      <= 1'b0;
      r_cnt        <= '0;
      r_rdata_q    <= '0;
      r_jtag_rdata <= '0;
      r_jtag_done  <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wren   <= 1'b0;
      r_ram_byteen <= '0;
      r_ram_wdata  <= '0;
    end else begin
      r_jtag_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_hold_pending | w_av_valid) begin
            r_state <= StAccess;
            if (w_grant_jtag) begin
              r_owner      <= OwnJtag;
              r_last_grant <= OwnJtag;
              r_op_wr      <= w_hold_wr;
              r_ram_addr   <= w_hold_addr;
              r_ram_wdata  <= w_hold_wdata;
              r_ram_byteen <= '1;
              r_ram_wren   <= w_hold_wr;
            end else begin
              r_owner      <= OwnAv;
              r_last_grant <= OwnAv;
              r_op_wr      <= av.av_write;
              r_ram_addr   <= av.av_address;
              r_ram_wdata  <= av.av_writedata;
              r_ram_byteen <= av.av_byteenable;
              // Writes without debugaccess still run the full sequence, just without a strobe.
              r_ram_wren   <= av.av_write & av.av_debugaccess;
            end
          end
        end
        StAccess: begin
          r_ram_wren <= 1'b0;
          if (r_op_wr) begin
            r_state     <= StAck;
            r_jtag_done <= (r_owner == OwnJtag);
          end else begin
            r_state <= StWait;
            r_cnt   <= CntW'(RD_LATENCY);
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CntW'(1)) begin
            r_state <= StAck;
            if (r_owner == OwnJtag) begin
              r_jtag_rdata <= ram_rdata;
              r_jtag_done  <= 1'b1;
            end else begin
              r_rdata_q <= ram_rdata;
            end
          end
        end
        StAck: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign jtag_rdata        = r_jtag_rdata;
  assign jtag_done         = r_jtag_done;
  assign jtag_busy         = w_hold_pending | (~w_idle & (r_owner == OwnJtag));
  assign av.av_readdata    = r_rdata_q;
  assign av.av_waitrequest = w_av_valid & ~((r_state == StAck) & (r_owner == OwnAv));
  assign ram_addr          = r_ram_addr;
  assign ram_wren          = r_ram_wren;
  assign ram_byteen        = r_ram_byteen;
  assign ram_wdata         = r_ram_wdata;

endmodule
